// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings and baud divider helper
package uart_pkg;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   localparam int OVERSAMPLE = 16;

   // Clocks per oversample tick, truncated, never below one.
   function automatic int uart_div(input int freq_hz, input int baud);
      int d;
      d = freq_hz / (baud * OVERSAMPLE);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_phy_rx.sv
// rtl/uart_phy_rx.sv - 8N1 receiver with mid-bit sampling on 16x ticks
module uart_phy_rx
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       tick,
   input  logic       rx_ack,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   output logic       rx_error
);

   logic [1:0] sync;
   logic       rxd_s;
   rx_state_t  state;
   logic [3:0] tick_cnt;
   logic [2:0] bit_idx;
   logic [7:0] shreg;
   logic       armed;

   assign rxd_s = sync[1];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync     <= 2'b11;
         state    <= RX_IDLE;
         tick_cnt <= 4'd0;
         bit_idx  <= 3'd0;
         shreg    <= 8'h00;
         armed    <= 1'b1;
         rx_data  <= 8'h00;
         rx_avail <= 1'b0;
         rx_error <= 1'b0;
      end else begin
         sync <= {sync[0], rxd};
         if (rx_ack) begin
            rx_avail <= 1'b0;
            rx_error <= 1'b0;
         end
         case (state)
            RX_IDLE: begin
               tick_cnt <= 4'd0;
               bit_idx  <= 3'd0;
               // A low stop bit may be a held break; re-arm only once the line is high again.
               if (rxd_s)
                  armed <= 1'b1;
               else if (armed)
                  state <= RX_START;
            end
            RX_START: begin
               if (tick) begin
                  if (tick_cnt == 4'd7) begin
                     tick_cnt <= 4'd0;
                     state    <= rxd_s ? RX_IDLE : RX_DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            RX_DATA: begin
               if (tick) begin
                  tick_cnt <= tick_cnt + 4'd1;
                  if (tick_cnt == 4'd15) begin
                     shreg   <= {rxd_s, shreg[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                     if (bit_idx == 3'd7)
                        state <= RX_STOP;
                  end
               end
            end
            RX_STOP: begin
               if (tick) begin
                  tick_cnt <= tick_cnt + 4'd1;
                  if (tick_cnt == 4'd15) begin
                     // Completion overrides a same-cycle ack; overrun only if the old byte stays unread.
                     rx_data  <= shreg;
                     rx_avail <= 1'b1;
                     rx_error <= ~rxd_s | (rx_avail & ~rx_ack);
                     armed    <= rxd_s;
                     state    <= RX_IDLE;
                  end
               end
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_phy.sv
// rtl/uart_phy.sv - full-duplex 8N1 UART PHY: tick dividers, transmitter, receiver instance
module uart_phy
   import uart_pkg::*;
#(
   parameter int freq_hz = 100000000,
   parameter int baud    = 115200
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       uart_rxd,
   output logic       uart_txd,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   output logic       rx_error,
   input  logic       rx_ack,
   input  logic [7:0] tx_data,
   input  logic       tx_wr,
   output logic       tx_busy
);

   localparam int DIV = uart_div(freq_hz, baud);
   localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   logic [DW-1:0] rx_div;
   logic [DW-1:0] tx_div;
   logic          rx_tick;
   logic          tx_tick;
   logic          tx_accept;
   tx_state_t     tx_state;
   logic [3:0]    tx_ticks;
   logic [2:0]    tx_bit;
   logic [7:0]    tx_shreg;

   assign rx_tick   = (rx_div == DIV_LAST);
   assign tx_tick   = (tx_div == DIV_LAST);
   assign tx_accept = tx_wr && (tx_state == TX_IDLE);

   always_ff @(posedge clk) begin
      if (reset || rx_tick)
         rx_div <= '0;
      else
         rx_div <= rx_div + DW'(1);
   end

   // The transmitter has its own divider so restarting its phase never disturbs reception.
   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state <= TX_IDLE;
         tx_div   <= '0;
         tx_ticks <= 4'd0;
         tx_bit   <= 3'd0;
         tx_shreg <= 8'h00;
         uart_txd <= 1'b1;
         tx_busy  <= 1'b0;
      end else begin
         tx_div <= (tx_accept || tx_tick) ? '0 : tx_div + DW'(1);
         if (tx_state != TX_IDLE && tx_tick)
            tx_ticks <= tx_ticks + 4'd1;
         case (tx_state)
            TX_IDLE: begin
               if (tx_wr) begin
                  tx_shreg <= tx_data;
                  uart_txd <= 1'b0;
                  tx_busy  <= 1'b1;
                  tx_ticks <= 4'd0;
                  tx_bit   <= 3'd0;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_tick && tx_ticks == 4'd15) begin
                  uart_txd <= tx_shreg[0];
                  tx_shreg <= {1'b0, tx_shreg[7:1]};
                  tx_state <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (tx_tick && tx_ticks == 4'd15) begin
                  if (tx_bit == 3'd7) begin
                     uart_txd <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     uart_txd <= tx_shreg[0];
                     tx_shreg <= {1'b0, tx_shreg[7:1]};
                     tx_bit   <= tx_bit + 3'd1;
                  end
               end
            end
            TX_STOP: begin
               if (tx_tick && tx_ticks == 4'd15) begin
                  tx_busy  <= 1'b0;
                  tx_state <= TX_IDLE;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   uart_phy_rx u_rx (
      .clk      (clk),
      .reset    (reset),
      .rxd      (uart_rxd),
      .tick     (rx_tick),
      .rx_ack   (rx_ack),
      .rx_data  (rx_data),
      .rx_avail (rx_avail),
      .rx_error (rx_error)
   );

endmodule
